// File: rtl/ranged_bus_pkg.sv
// Shared types for the ranged bus FIFO.
// Mapping modes and a bus width helper.
package ranged_bus_pkg;

  typedef enum logic [1:0] {
    MAP_PASS  = 2'd0,
    MAP_REV   = 2'd1,
    MAP_CROSS = 2'd2,
    MAP_RSVD  = 2'd3
  } map_mode_e;

  function automatic int bus_width(
    input int msb,
    input int lsb
  );
    return msb - lsb + 1;
  endfunction

endpackage

// File: rtl/ranged_bus_map.sv
// Combinational index mapper between a descending
// and an ascending bus: pass, reverse or cross.
module ranged_bus_map
  import ranged_bus_pkg::*;
#(
  parameter int MSB = 2,
  parameter int LSB = -2
) (
  input  logic [1:0]     mode,
  input  logic [MSB:LSB] a,
  input  logic [LSB:MSB] b,
  output logic [MSB:LSB] ya,
  output logic [LSB:MSB] yb
);

  localparam int W = bus_width(MSB, LSB);

  logic is_rev;
  logic is_cross;

  assign is_rev   = (mode == MAP_REV);
  assign is_cross = (mode == MAP_CROSS);

  // Walk by offset so every index is a constant,
  // including the negative ones.
  for (genvar i = 0; i < W; i++) begin : g_bit
    localparam int K = LSB + i;
    localparam int R = MSB - i;
    assign ya[K] = is_rev   ? a[R] :
                   is_cross ? b[K] : a[K];
    assign yb[K] = is_rev   ? b[R] :
                   is_cross ? a[K] : b[K];
  end

endmodule

// File: rtl/ranged_bus_fifo.sv
// First-word fall-through FIFO for two mixed-direction buses.
// Optional parity: define RANGED_BUS_FIFO_PARITY_EN.
module ranged_bus_fifo
  import ranged_bus_pkg::*;
#(
  parameter int MSB   = 2,
  parameter int LSB   = -2,
  parameter int DEPTH = 4,
  parameter logic [bus_width(MSB, LSB)-1:0] FILL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [MSB:LSB]           i0,
  input  logic [LSB:MSB]           i1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MSB:LSB]           o0,
  output logic [LSB:MSB]           o1,
  output logic [$clog2(DEPTH):0]   count
`ifdef RANGED_BUS_FIFO_PARITY_EN
  ,
  input  logic                     inj_par,
  output logic                     par_err
`endif
);

  localparam int W  = bus_width(MSB, LSB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]   mode_mem [DEPTH];
  logic [W-1:0] a_mem    [DEPTH];
  logic [W-1:0] b_mem    [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  logic [MSB:LSB] hd_a;
  logic [LSB:MSB] hd_b;
  logic [1:0]     hd_mode;
  logic [MSB:LSB] map_a;
  logic [LSB:MSB] map_b;

  // Ready never looks at out_ready, so a full FIFO
  // refuses a push even when it pops that cycle.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mode_mem[wr_ptr] <= mode;
      a_mem[wr_ptr]    <= i0;
      b_mem[wr_ptr]    <= i1;
    end
  end

  assign hd_mode = mode_mem[rd_ptr];
  assign hd_a    = a_mem[rd_ptr];
  assign hd_b    = b_mem[rd_ptr];

  ranged_bus_map #(
    .MSB (MSB),
    .LSB (LSB)
  ) u_map (
    .mode (hd_mode),
    .a    (hd_a),
    .b    (hd_b),
    .ya   (map_a),
    .yb   (map_b)
  );

  assign o0 = out_valid ? map_a : FILL;
  assign o1 = out_valid ? map_b : FILL;

`ifdef RANGED_BUS_FIFO_PARITY_EN
  logic par_mem [DEPTH];

  // Even parity per entry; inj_par corrupts it on purpose.
  always_ff @(posedge clk) begin
    if (push) par_mem[wr_ptr] <= (^{i0, i1}) ^ inj_par;
  end

  assign par_err = out_valid &&
                   ((^{hd_a, hd_b}) != par_mem[rd_ptr]);
`endif

endmodule

// File: tb/tb_ranged_bus_fifo.sv
// Self-checking bench for ranged_bus_fifo.
// Table vectors, directed corners and a queue model.
module tb_ranged_bus_fifo;

  localparam int MSB   = 2;
  localparam int LSB   = -2;
  localparam int DEPTH = 4;
  localparam logic [4:0] FILL = 5'b10101;

  logic           clk = 0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     mode;
  logic [MSB:LSB] i0;
  logic [LSB:MSB] i1;
  logic           out_valid;
  logic           out_ready;
  logic [MSB:LSB] o0;
  logic [LSB:MSB] o1;
  logic [2:0]     count;
`ifdef RANGED_BUS_FIFO_PARITY_EN
  logic           inj_par;
  logic           par_err;
`endif

  ranged_bus_fifo #(
    .MSB   (MSB),
    .LSB   (LSB),
    .DEPTH (DEPTH),
    .FILL  (FILL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .i0        (i0),
    .i1        (i1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o0        (o0),
    .o1        (o1),
    .count     (count)
`ifdef RANGED_BUS_FIFO_PARITY_EN
    ,
    .inj_par   (inj_par),
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     mode;
    logic [MSB:LSB] a;
    logic [LSB:MSB] b;
    logic           bad;
  } ent_t;

  typedef struct {
    logic [1:0] mode;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] e0;
    logic [4:0] e1;
  } vec_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected head outputs from the mapping rules, index by index.
  task automatic exp_out(output logic [MSB:LSB] e0,
                         output logic [LSB:MSB] e1);
    ent_t h;
    e0 = FILL;
    e1 = FILL;
    if (q.size() != 0) begin
      h = q[0];
      for (int k = LSB; k <= MSB; k++) begin
        case (h.mode)
          2'd1: begin
            e0[k] = h.a[MSB+LSB-k];
            e1[k] = h.b[MSB+LSB-k];
          end
          2'd2: begin
            e0[k] = h.b[k];
            e1[k] = h.a[k];
          end
          default: begin
            e0[k] = h.a[k];
            e1[k] = h.b[k];
          end
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [MSB:LSB] e0;
    logic [LSB:MSB] e1;
    exp_out(e0, e1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".o0"}, 32'(o0), 32'(e0));
    chk({tag, ".o1"}, 32'(o1), 32'(e1));
`ifdef RANGED_BUS_FIFO_PARITY_EN
    chk({tag, ".par_err"}, 32'(par_err),
        32'((q.size() != 0) && q[0].bad));
`endif
  endtask

  // Drive one cycle from a falling edge, advance model, check.
  task automatic step(input string tag,
                      input logic iv,
                      input logic [1:0] md,
                      input logic [4:0] a,
                      input logic [4:0] b,
                      input logic ordy,
                      input logic ip);
    logic do_push;
    logic do_pop;
    ent_t e;
    in_valid  = iv;
    mode      = md;
    i0        = a;
    i1        = b;
    out_ready = ordy;
`ifdef RANGED_BUS_FIFO_PARITY_EN
    inj_par   = ip;
`endif
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() != 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.mode = md;
      e.a    = a;
      e.b    = b;
      e.bad  = ip;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid  = 0;
    out_ready = 0;
    check_all(tag);
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{2'd0, 5'b11000, 5'b00011, 5'b11000, 5'b00011};
    vt[1] = '{2'd1, 5'b11000, 5'b00011, 5'b00011, 5'b11000};
    vt[2] = '{2'd2, 5'b10000, 5'b10000, 5'b00001, 5'b00001};
    vt[3] = '{2'd3, 5'b10110, 5'b01101, 5'b10110, 5'b01101};
    vt[4] = '{2'd1, 5'b10110, 5'b01101, 5'b01101, 5'b10110};
    vt[5] = '{2'd2, 5'b11100, 5'b00101, 5'b10100, 5'b00111};

    rst       = 1;
    in_valid  = 0;
    out_ready = 0;
    mode      = 0;
    i0        = '0;
    i1        = '0;
`ifdef RANGED_BUS_FIFO_PARITY_EN
    inj_par   = 0;
`endif
    @(negedge clk);
    check_all("reset");
    chk("reset.o0_fill", 32'(o0), 32'(5'b10101));
    rst = 0;
    @(negedge clk);
    check_all("idle");

    // Table vectors: push, check head mapping, pop.
    for (int v = 0; v < 6; v++) begin
      step($sformatf("vec%0d.push", v), 1'b1, vt[v].mode,
           vt[v].a, vt[v].b, 1'b0, 1'b0);
      chk($sformatf("vec%0d.o0", v), 32'(o0), 32'(vt[v].e0));
      chk($sformatf("vec%0d.o1", v), 32'(o1), 32'(vt[v].e1));
      step($sformatf("vec%0d.pop", v), 1'b0, 2'd0,
           5'd0, 5'd0, 1'b1, 1'b0);
    end

    // Named bits from the cross case.
    step("bits.push", 1'b1, 2'd2, 5'b10000, 5'b10000, 1'b0, 1'b0);
    chk("bits.o0[-2]", 32'(o0[-2]), 32'd1);
    chk("bits.o1[2]", 32'(o1[2]), 32'd1);
    chk("bits.o0[2]", 32'(o0[2]), 32'd0);
    step("bits.pop", 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0);

    // Empty FIFO ignores out_ready.
    step("empty_pop", 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0);

    // Fill to full, drop a fifth push.
    for (int n = 0; n < 4; n++)
      step($sformatf("fill%0d", n), 1'b1, 2'(n),
           5'(n + 3), 5'(9 * n + 1), 1'b0, 1'b0);
    chk("full.count", 32'(count), 32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    step("drop5", 1'b1, 2'd0, 5'b11111, 5'b11111, 1'b0, 1'b0);
    chk("drop5.count", 32'(count), 32'd4);
    // Push+pop at full: pop only. Then steady push+pop across wrap.
    step("fullpp", 1'b1, 2'd1, 5'b01010, 5'b00110, 1'b1, 1'b0);
    chk("fullpp.count", 32'(count), 32'd3);
    for (int n = 0; n < 6; n++)
      step($sformatf("wrap%0d", n), 1'b1, 2'(n + 1),
           5'(7 * n + 2), 5'(5 * n + 11), 1'b1, 1'b0);
    chk("wrap.count", 32'(count), 32'd3);
    for (int n = 0; n < 3; n++)
      step($sformatf("drain%0d", n), 1'b0, 2'd0,
           5'd0, 5'd0, 1'b1, 1'b0);

    // Reset while entries are in flight.
    step("mid.p0", 1'b1, 2'd1, 5'b01110, 5'b10011, 1'b0, 1'b0);
    step("mid.p1", 1'b1, 2'd2, 5'b00111, 5'b11001, 1'b0, 1'b0);
    #2 rst = 1;
    #1 q.delete();
    check_all("midrst");
    chk("midrst.o1_fill", 32'(o1), 32'(5'b10101));
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_all("midrst.rel");

`ifdef RANGED_BUS_FIFO_PARITY_EN
    // Corrupt entry flags only while at the head.
    step("par.c0", 1'b1, 2'd0, 5'b10110, 5'b00101, 1'b0, 1'b0);
    step("par.bad", 1'b1, 2'd1, 5'b01100, 5'b11101, 1'b0, 1'b1);
    step("par.c1", 1'b1, 2'd2, 5'b00011, 5'b10001, 1'b0, 1'b0);
    chk("par.c0_head", 32'(par_err), 32'd0);
    step("par.pop0", 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("par.bad_head", 32'(par_err), 32'd1);
    step("par.pop1", 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("par.c1_head", 32'(par_err), 32'd0);
    step("par.pop2", 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0);
`endif

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++)
      step("rand", 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           5'($urandom), 5'($urandom),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
